// File: rtl/mux_rr_arbiter_if.sv
// Handshake and mux-control bundle between the four requesters, the 4:1 mux and the arbiter.
// Arbiter sees the master view; requesters/consumer see the slave view.
interface mux_rr_arbiter_if;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic [3:0] req_ready;
    logic       out_valid;
    logic       busy;

    // Handshake: a beat transfers on any cycle where out_valid and out_ready are both high;
    // the granted requester holds req high until req_ready[i] shows its beat was taken.
    modport master (
        input  req,
        input  out_ready,
        output sel,
        output grant,
        output req_ready,
        output out_valid,
        output busy
    );

    modport slave (
        output req,
        output out_ready,
        input  sel,
        input  grant,
        input  req_ready,
        input  out_valid,
        input  busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering a 4:1 mux between four requesters, with a per-tenure burst limit.
// busy is the registered FSM state (high exactly in GRANT).
module mux_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input logic              clk,
    input logic              rst,
    mux_rr_arbiter_if.master bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t           state;
    logic [1:0]       sel_q;
    logic [3:0]       grant_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       ptr;

    logic             out_valid;
    logic             beat;
    logic             release_now;
    logic [1:0]       arb_base;
    logic [2:0]       arb;

    // Returns {found, winner}; search starts just after base so base itself is checked last.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = base + 2'(k);
            if (!res[2] && r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        out_valid   = (state == GRANT) && bus.req[sel_q];
        beat        = out_valid && bus.out_ready;
        release_now = (beat && (cnt == LAST_BEAT)) || !bus.req[sel_q];
        arb_base    = (state == GRANT) ? sel_q : ptr;
        arb         = rr_pick(bus.req, arb_base);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
            cnt     <= '0;
            ptr     <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (arb[2]) begin
                        state   <= GRANT;
                        sel_q   <= arb[1:0];
                        grant_q <= 4'b0001 << arb[1:0];
                        busy_q  <= 1'b1;
                        cnt     <= '0;
                        ptr     <= arb[1:0];
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        // Re-arbitrate in the same cycle so back-to-back tenures have no bubble.
                        if (arb[2]) begin
                            sel_q   <= arb[1:0];
                            grant_q <= 4'b0001 << arb[1:0];
                            cnt     <= '0;
                            ptr     <= arb[1:0];
                        end else begin
                            state   <= IDLE;
                            grant_q <= 4'b0000;
                            busy_q  <= 1'b0;
                            cnt     <= '0;
                        end
                    end else if (beat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= 4'b0000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid;
    assign bus.req_ready = grant_q & {4{bus.out_ready}};

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: expected accepted beats (by grant) are queued per scenario
// and a negedge monitor pops one per observed handshake; direct checks cover state snapshots.
module tb_mux_rr_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [3:0] exp_q[$];

    mux_rr_arbiter_if bus();

    mux_rr_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic drive(input logic [3:0] r, input logic rd);
        bus.req       = r;
        bus.out_ready = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'b0000, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_n(input logic [3:0] g, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(g);
    endtask

    // samples at the next negedge, mid-window
    task automatic snap(input string name, input logic [3:0] g, input logic [1:0] s,
                        input logic b, input logic v);
        @(negedge clk);
        check({name, "_grant"}, {4'b0, bus.grant}, {4'b0, g});
        check({name, "_sel"}, {6'b0, bus.sel}, {6'b0, s});
        check({name, "_busy"}, {7'b0, bus.busy}, {7'b0, b});
        check({name, "_valid"}, {7'b0, bus.out_valid}, {7'b0, v});
    endtask

    task automatic drain(input string name);
        check({name, "_drain"}, 8'(exp_q.size()), 8'd0);
        exp_q.delete();
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            check("req_ready", {4'b0, bus.req_ready}, {4'b0, bus.grant & {4{bus.out_ready}}});
            if (bus.busy) check("grant_onehot", {4'b0, bus.grant}, {4'b0, 4'b0001 << bus.sel});
            else          check("idle_quiet", {3'b0, bus.grant, bus.out_valid}, 8'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {4'b0, bus.grant}, 8'd0);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    check("beat_grant", {4'b0, bus.grant}, {4'b0, e});
                end
            end
        end
    end

    logic [3:0] t_req[10];
    logic       t_rdy[10];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        drive(4'b0000, 1'b0);
        #1;

        // reset then idle
        do_reset();
        for (int i = 0; i < 5; i++) begin
            snap("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
            tick();
        end

        // single requester: two full tenures, re-granted without a gap
        push_n(4'b0100, 8);
        drive(4'b0100, 1'b1);
        tick();
        snap("single_first", 4'b0100, 2'd2, 1'b1, 1'b1);
        repeat (8) tick();
        drive(4'b0000, 1'b0);
        tick();
        tick();
        snap("single_end", 4'b0000, 2'd2, 1'b0, 1'b0);
        drain("single");

        // full rotation, 4 beats each, pointer freshly reset
        do_reset();
        push_n(4'b0001, 4); push_n(4'b0010, 4); push_n(4'b0100, 4);
        push_n(4'b1000, 4); push_n(4'b0001, 4);
        drive(4'b1111, 1'b1);
        tick();
        snap("rot_first", 4'b0001, 2'd0, 1'b1, 1'b1);
        repeat (20) tick();
        drive(4'b0000, 1'b0);
        tick();
        tick();
        drain("rotation");

        // backpressure: beats only on ready=1, release after the 4th, then requester 1
        do_reset();
        push_n(4'b0001, 4); push_n(4'b0010, 1);
        t_req = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0011,
                  4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0000};
        t_rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(t_req[i], t_rdy[i]);
            if (i == 3) snap("bp_stall", 4'b0001, 2'd0, 1'b1, 1'b1);
            if (i == 8) snap("bp_next", 4'b0010, 2'd1, 1'b1, 1'b1);
            tick();
        end
        drive(4'b0000, 1'b0);
        snap("bp_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
        tick();
        drain("backpressure");

        // early withdrawal of requester 1 hands over to 3 with a fresh counter
        push_n(4'b0010, 2); push_n(4'b1000, 4); push_n(4'b0001, 1);
        drive(4'b0010, 1'b0); tick();
        drive(4'b1010, 1'b1); tick();
        drive(4'b1010, 1'b1); tick();
        drive(4'b1000, 1'b1);
        snap("wd_drop", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        drive(4'b1001, 1'b1);
        snap("wd_new", 4'b1000, 2'd3, 1'b1, 1'b1);
        tick();
        repeat (3) tick();
        drive(4'b0001, 1'b1);
        snap("wd_after_burst", 4'b0001, 2'd0, 1'b1, 1'b1);
        tick();
        drive(4'b0000, 1'b0); tick();
        snap("wd_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        drain("withdraw");

        // reset mid-tenure abandons the grant and restores pointer to 3
        do_reset();
        push_n(4'b0100, 2); push_n(4'b0001, 1);
        drive(4'b0100, 1'b0); tick();
        drive(4'b0100, 1'b1); tick();
        drive(4'b0100, 1'b1); tick();
        rst = 1'b1;
        drive(4'b0100, 1'b0); tick();
        rst = 1'b0;
        drive(4'b1111, 1'b1);
        snap("rst_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 1'b0);
        drive(4'b1111, 1'b1);
        snap("rst_regrant", 4'b0001, 2'd0, 1'b1, 1'b1);
        tick();
        drive(4'b0000, 1'b0); tick();
        tick();
        drain("reset_mid");

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares the 4-input, 4-bit multiplexer among four requesters.
- Drives the mux `sel` and a one-hot grant. Forwards a valid/ready handshake between the granted requester and the single downstream consumer.
- Bounds each tenure with a burst limit so no requester starves the others.
- Sits directly in front of the 4:1 mux. The mux output data is not routed through this block.

Parameters:
- MAX_BURST, 4, maximum accepted beats per grant tenure (legal range 1..15).
- CNT_W, 4, width of the beat counter; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  req[i] high while requester i has a beat to send; must stay high until its beat is accepted.
- out_ready  input  1  downstream accepts the current beat.
- sel  output  2  registered select to the mux (in0..in3 = requesters 0..3).
- grant  output  4  registered one-hot grant; all-zero when idle.
- req_ready  output  4  combinational: req_ready[i] = grant[i] & out_ready.
- out_valid  output  1  combinational: state==GRANT & req[sel].
- busy  output  1  registered: high in GRANT.

Behaviour:
- Reset (rst high at an edge, dominant over everything):
  - state=IDLE, sel=0, grant=0, busy=0, beat counter=0.
  - Last-winner pointer=3, so requester 0 has first priority.
  - Reset mid-tenure drops the grant at that edge. An in-flight beat is abandoned, not completed.
- States: IDLE, GRANT.
- Arbitration function: search order is (ptr+1), (ptr+2), (ptr+3), (ptr+4) mod 4; first i with req[i]=1 wins. The last winner therefore has lowest priority but is still eligible.
- IDLE:
  - grant=0, out_valid=0, and sel holds its previous value.
  - If any req is high, the arbitration result is registered at the next edge: sel=winner, grant=1<<winner, ptr=winner, counter=0, state=GRANT.
  - Latency from req rising to grant is 1 cycle.
- GRANT:
  - beat = out_valid & out_ready; each beat increments the counter.
  - Release conditions, evaluated each cycle, are:
    - (a) beat occurs and counter+1 == MAX_BURST;
    - (b) req[sel]==0, i.e. the requester withdrew or had finished the previous cycle.
  - On release, rearbitrate in the same cycle using the current req vector with ptr=sel.
    - If a winner exists, the next edge loads the new grant with counter=0 and stays in GRANT (no bubble). This can re-grant the same requester if it is the only one requesting.
    - If no winner exists, go to IDLE with grant=0.
  - Without a release, the grant, sel and counter hold (counter increments only on a beat).
  - out_ready low stalls with no state change.
- Simultaneous events:
  - A beat on the MAX_BURST-th count together with other requests: the new grant takes effect the next cycle.
  - A req deasserting in the same cycle as the last beat counts as a single release.
- Width rules: the counter never exceeds MAX_BURST-1 while held, and there is no wrap. ptr arithmetic is modulo 4.
- Invariants:
  - grant is zero or one-hot, and equals 1<<sel whenever busy=1.
  - out_valid never asserts in IDLE.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then req=0000 → sel=0, grant=0000, out_valid=0, busy=0 for 5 cycles.
- Single requester, MAX_BURST=4: req=0100 held, out_ready=1 → grant=0100 one cycle after req, sel=2, 4 beats accepted. Because req stays high, grant drops for no cycle and is re-granted to 2 (counter restarts).
- Round-robin rotation: req=1111 held, out_ready=1 → grant sequence 0001, 0010, 0100, 1000, 0001, each lasting 4 beats, with zero idle cycles between tenures.
- Backpressure: grant=0001, out_ready toggles 1,0,0,1,1,0,1 → exactly 4 beats counted (on the 1s), grant held through the stalls, and release after the 4th accepted beat.
- Early withdrawal: grant to 1 and req[1] drops after 2 beats while req[3]=1 → next cycle grant=1000, sel=3, counter=0. If no other request is pending, the block goes to IDLE with grant=0000.
- Reset mid-tenure: grant=0100 with 2 beats done, then rst=1 → next edge grant=0000, sel=0. After release with req=1111, the first grant is 0001 (pointer reset to 3).
